// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: converts an IN_W-bit instruction field into an OUT_W-bit
// operand (zero-ext, sign-ext, upper placement, shift-amount) and queues the
// result in a 2-entry in-order buffer with valid/ready on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream presents a field
//   in_ready   unit accepts this cycle (registered state and rst only)
//   in_data    raw IN_W-bit field
//   in_mode    00 zero-ext, 01 sign-ext, 10 upper, 11 shift amount
//   out_valid  buffer head holds a result
//   out_ready  downstream consumes the head this cycle
//   out_data   extended operand at the head, zero when empty
module ext_unit_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SA_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam int unsigned PAD_W    = OUT_W - IN_W;
  localparam int unsigned SA_PAD_W = OUT_W - SA_W;
  localparam int unsigned DEPTH    = 2;

  logic [OUT_W-1:0] mem [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [OUT_W-1:0] ext_c;
  logic             push;
  logic             pop;

  // Extension is done before storage so the buffer holds final operands.
  always_comb begin
    ext_c = '0;
    case (in_mode)
      2'b00:   ext_c = {{PAD_W{1'b0}}, in_data};
      2'b01:   ext_c = {{PAD_W{in_data[IN_W-1]}}, in_data};
      2'b10:   ext_c = {in_data, {PAD_W{1'b0}}};
      default: ext_c = {{SA_PAD_W{1'b0}}, in_data[SA_W-1:0]};
    endcase
  end

  // Handshake flags depend only on stored state, never on out_ready.
  assign in_ready  = (count != 2'd2) && !rst;
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Buffer storage, pointers and occupancy; reset discards all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ext_c;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Scoreboard bench for ext_unit_pipe: default-width instance plus an
// 8/16/4 instance, reference results computed arithmetically.
module tb_ext_unit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [31:0] out_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data;
  logic [1:0]  b_in_mode;
  logic [15:0] b_out_data;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;
  bit rand_rdy = 1'b0;
  longint unsigned qa[$];
  longint unsigned qb[$];

  always #5 clk = ~clk;

  ext_unit_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  ext_unit_pipe #(.IN_W(8), .OUT_W(16), .SA_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data)
  );

  // Reference conversion expressed as plain integer arithmetic.
  function automatic longint unsigned model(longint unsigned d, int m, int iw, int ow, int sw);
    longint unsigned one = 64'd1;
    case (m)
      0: return d;
      1: return (d >= (one << (iw - 1))) ? d + ((one << ow) - (one << iw)) : d;
      2: return d * (one << (ow - iw));
      default: return d % (one << sw);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one field and hold it until accepted; n = cycles taken.
  task automatic send(input logic [15:0] d, input logic [1:0] m, output int n);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    n = 0;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 64'(n), 64'(0));
  endtask

  // Directed single transfer into an empty buffer; result due next cycle.
  task automatic one(input logic [15:0] d, input logic [1:0] m, input logic [31:0] exp);
    int n;
    out_ready = 1'b1;
    send(d, m, n);
    in_valid = 1'b0;
    @(negedge clk);
    chk("dir_valid", 64'(out_valid), 64'(1));
    chk("dir_data", 64'(out_data), 64'(exp));
  endtask

  // Scoreboard producers: record the expected result of every accepted field.
  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (in_valid && in_ready) qa.push_back(model(64'(in_data), int'(in_mode), 16, 32, 5));
      if (b_in_valid && b_in_ready) qb.push_back(model(64'(b_in_data), int'(b_in_mode), 8, 16, 4));
    end
  end

  // Monitor: occupancy-derived flags and in-order result comparison.
  always @(negedge clk) begin
    longint unsigned e;
    if (started) begin
      chk("a_valid", 64'(out_valid), 64'(qa.size() != 0));
      chk("a_ready", 64'(in_ready), 64'(!rst && qa.size() < 2));
      if (!out_valid) chk("a_idle_zero", 64'(out_data), 64'(0));
      else if (out_ready && !rst && qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_data", 64'(out_data), e);
      end
      chk("b_valid", 64'(b_out_valid), 64'(qb.size() != 0));
      if (!b_out_valid) chk("b_idle_zero", 64'(b_out_data), 64'(0));
      else if (b_out_ready && !rst && qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_data", 64'(b_out_data), e);
      end
    end
  end

  // Random backpressure source while enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    int n;
    logic [7:0]  bd [3] = '{8'h80, 8'hAB, 8'hFF};
    logic [1:0]  bm [3] = '{2'b01, 2'b10, 2'b11};
    logic [15:0] be [3] = '{16'hFF80, 16'hAB00, 16'h000F};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;
    step();
    chk("rst_in_ready_low", 64'(in_ready), 64'(0));
    step();
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Mode table with default widths.
    one(16'h8001, 2'b00, 32'h00008001);
    one(16'h8001, 2'b01, 32'hFFFF8001);
    one(16'h7FFF, 2'b01, 32'h00007FFF);
    one(16'h1234, 2'b10, 32'h12340000);
    one(16'hFFFF, 2'b11, 32'h0000001F);
    step();

    // Backpressure: A, B fill the buffer, C waits.
    out_ready = 1'b0;
    send(16'h0001, 2'b00, n);
    send(16'h8000, 2'b01, n);
    chk("bp_full_ready", 64'(in_ready), 64'(0));
    in_data = 16'h0003; in_mode = 2'b11;
    repeat (3) begin
      step();
      chk("bp_hold_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    step();
    chk("bp_ready_return", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    repeat (3) step();

    // Streaming at count=1: every field accepted on first offer.
    for (int i = 0; i < 8; i++) begin
      send(16'($urandom), 2'($urandom), n);
      chk("stream_no_bubble", 64'(n), 64'(1));
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Pointer wrap with out_ready toggling.
    for (int i = 0; i < 5; i++) begin
      out_ready = (i % 2 == 1);
      send(16'($urandom), 2'($urandom), n);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    // Reset with two entries buffered and downstream ready.
    out_ready = 1'b0;
    send(16'h1111, 2'b00, n);
    send(16'h2222, 2'b01, n);
    in_valid = 1'b0;
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 64'(in_ready), 64'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_data", 64'(out_data), 64'(0));
    chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
    one(16'h00FF, 2'b00, 32'h000000FF);
    step();

    // Randomized traffic with random backpressure and idle gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end else send(16'($urandom), 2'($urandom), n);
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    step();
    out_ready = 1'b1;
    repeat (4) step();

    // Narrow instance: directed table then random fields.
    for (int i = 0; i < 23; i++) begin
      b_in_valid = 1'b1;
      b_in_data = (i < 3) ? bd[i] : 8'($urandom);
      b_in_mode = (i < 3) ? bm[i] : 2'($urandom);
      step();
      b_in_valid = 1'b0;
      @(negedge clk);
      if (i < 3) chk("b_dir_data", 64'(b_out_data), 64'(be[i]));
    end
    repeat (3) step();

    chk("a_drained", 64'(qa.size()), 64'(0));
    chk("b_drained", 64'(qb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
